// File: rtl/silent_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// silent_pkg : shared types, constants and scale helper for the frame source
// Revision   : 1.0
// ---------------------------------------------------------------------------
package silent_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int          DEFAULT_DEPTH = 249;
  localparam logic [15:0] INTENSITY_SAT = 16'hFFFF;
  localparam int          MOD_UNITY     = 256;
  localparam int          MOD_SHIFT     = $clog2(MOD_UNITY);
  localparam int          MOD_WIDTH     = MOD_SHIFT + 1;
  localparam int          PROD_WIDTH    = 16 + MOD_WIDTH;

  // Unity-scaled multiply; anything that no longer fits 16 bits clamps to full scale.
  function automatic logic [15:0] scale_sat(input logic [15:0]          intensity,
                                            input logic [MOD_WIDTH-1:0] mod);
    logic [PROD_WIDTH-1:0]           product;
    logic [PROD_WIDTH-MOD_SHIFT-1:0] shifted;
    product = PROD_WIDTH'(intensity) * PROD_WIDTH'(mod);
    shifted = product[PROD_WIDTH-1:MOD_SHIFT];
    if (shifted > (PROD_WIDTH-MOD_SHIFT)'(INTENSITY_SAT)) begin
      return INTENSITY_SAT;
    end
    return shifted[15:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/silent_stream_source_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// silent_stream_source_if : control, BRAM read port and output stream bundle
// Revision                : 1.0
// ---------------------------------------------------------------------------
interface silent_stream_source_if
  import silent_pkg::*;
#(
  parameter int ADDR_WIDTH = 14
) ();

  logic                  update;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [MOD_WIDTH-1:0]  mod;
  logic                  overrun_clr;
  logic                  busy;
  logic                  overrun;
  logic [ADDR_WIDTH-1:0] bram_addr;
  logic [31:0]           bram_rdata;
  logic                  dout_valid;
  logic [15:0]           intensity_out;
  logic [15:0]           phase_out;

  // Controller / memory / sink side
  modport master (
    output update, base_addr, mod, overrun_clr, bram_rdata,
    input  busy, overrun, bram_addr, dout_valid, intensity_out, phase_out
  );

  // Frame source side
  modport slave (
    input  update, base_addr, mod, overrun_clr, bram_rdata,
    output busy, overrun, bram_addr, dout_valid, intensity_out, phase_out
  );

endinterface
`default_nettype wire

// File: rtl/mod_scaler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mod_scaler : registered intensity scale with saturation, phase pass-through
// Revision   : 1.0
// ---------------------------------------------------------------------------
module mod_scaler
  import silent_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic                 in_first,
  input  logic [15:0]          in_intensity,
  input  logic [15:0]          in_phase,
  input  logic [MOD_WIDTH-1:0] in_mod,
  output logic                 out_first,
  output logic [15:0]          out_intensity,
  output logic [15:0]          out_phase
);

  // Data registers only load on valid beats so the outputs hold between frames.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_first     <= 1'b0;
      out_intensity <= '0;
      out_phase     <= '0;
    end else begin
      out_first <= in_valid & in_first;
      if (in_valid) begin
        out_intensity <= scale_sat(in_intensity, in_mod);
        out_phase     <= in_phase;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/silent_stream_source.sv
`default_nettype none
// ---------------------------------------------------------------------------
// silent_stream_source : BRAM frame fetch, intensity scale and strobed stream
// Revision             : 1.0
// ---------------------------------------------------------------------------
module silent_stream_source
  import silent_pkg::*;
#(
  parameter int DEPTH        = DEFAULT_DEPTH,
  parameter int ADDR_WIDTH   = 14,
  parameter int READ_LATENCY = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  silent_stream_source_if.slave  bus
);

  localparam int                   CNT_WIDTH  = $clog2(DEPTH + READ_LATENCY + 2);
  localparam logic [CNT_WIDTH-1:0] LAST_BEAT  = CNT_WIDTH'(DEPTH - 1);
  localparam logic [CNT_WIDTH-1:0] DRAIN_LAST = CNT_WIDTH'(READ_LATENCY);

  state_t                  r_state;
  logic [CNT_WIDTH-1:0]    r_cnt;
  logic [ADDR_WIDTH-1:0]   r_base;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [MOD_WIDTH-1:0]    r_mod;
  logic                    r_overrun;
  logic [READ_LATENCY-1:0] r_vld;
  logic [READ_LATENCY-1:0] r_fst;

  logic                    w_accept;
  logic                    w_reject;
  logic                    w_issue;
  logic                    w_first;
  logic [ADDR_WIDTH-1:0]   w_next_addr;

  assign w_accept    = bus.update && (r_state == IDLE);
  assign w_reject    = bus.update && (r_state != IDLE);
  assign w_issue     = (r_state == FETCH);
  assign w_first     = w_issue && (r_cnt == '0);
  // Address arithmetic wraps naturally at the BRAM address width.
  assign w_next_addr = r_base + ADDR_WIDTH'(r_cnt + CNT_WIDTH'(1));

  // r_cnt is the fetch index k in FETCH and the flush counter in DRAIN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_base  <= '0;
      r_addr  <= '0;
      r_mod   <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state <= FETCH;
            r_cnt   <= '0;
            r_base  <= bus.base_addr;
            r_addr  <= bus.base_addr;
            r_mod   <= bus.mod;
          end
        end
        FETCH: begin
          if (r_cnt == LAST_BEAT) begin
            r_state <= DRAIN;
            r_cnt   <= '0;
          end else begin
            r_cnt  <= r_cnt + CNT_WIDTH'(1);
            r_addr <= w_next_addr;
          end
        end
        DRAIN: begin
          // Covers the BRAM latency plus the scaler register for the final beat.
          if (r_cnt == DRAIN_LAST) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_WIDTH'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overrun <= 1'b0;
    end else if (w_reject) begin
      r_overrun <= 1'b1;
    end else if (bus.overrun_clr) begin
      r_overrun <= 1'b0;
    end
  end

  // Stage 0 is the registered address itself; the tail lines up with bram_rdata.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      r_fst <= '0;
    end else begin
      r_vld[0] <= w_issue;
      r_fst[0] <= w_first;
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_fst[i] <= r_fst[i-1];
      end
    end
  end

  mod_scaler u_mod_scaler (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (r_vld[READ_LATENCY-1]),
    .in_first      (r_fst[READ_LATENCY-1]),
    .in_intensity  (bus.bram_rdata[31:16]),
    .in_phase      (bus.bram_rdata[15:0]),
    .in_mod        (r_mod),
    .out_first     (bus.dout_valid),
    .out_intensity (bus.intensity_out),
    .out_phase     (bus.phase_out)
  );

  assign bus.busy      = (r_state != IDLE);
  assign bus.overrun   = r_overrun;
  assign bus.bram_addr = r_addr;

endmodule
`default_nettype wire

// File: tb/tb_silent_stream_source.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_silent_stream_source : scoreboard bench with a frame-level reference model
// Revision                : 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_silent_stream_source;

  localparam int DEPTH    = 249;
  localparam int AW       = 8;
  localparam int RL       = 2;
  localparam int PERIOD   = DEPTH + RL + 2;
  localparam int MEM_SIZE = 1 << AW;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  silent_stream_source_if #(.ADDR_WIDTH(AW)) bus ();

  silent_stream_source #(
    .DEPTH        (DEPTH),
    .ADDR_WIDTH   (AW),
    .READ_LATENCY (RL)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Drive-data memory with RL cycles of read latency
  logic [31:0] mem     [MEM_SIZE];
  logic [31:0] rd_pipe [RL];
  always @(posedge clk) begin
    rd_pipe[0] <= mem[bus.bram_addr];
    for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bus.bram_rdata = rd_pipe[RL-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [15:0] inten; logic [15:0] phase; } beat_t;
  typedef struct { int c; logic [AW-1:0] a; } addr_t;
  typedef struct { int c; logic v; } busy_t;

  beat_t beat_q  [$];
  int    start_q [$];
  addr_t addr_q  [$];
  busy_t busy_q  [$];

  int tests = 0;
  int fails = 0;
  bit frame_active = 1'b0;
  int last_e = 0;
  bit ovr_model = 1'b0;

  logic [8:0]  mods     [5] = '{9'd128, 9'd256, 9'd511, 9'd0, 9'd256};
  logic [15:0] specials [5] = '{16'h8000, 16'hFFFF, 16'hC000, 16'h7777, 16'h0100};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] scale(input logic [15:0] x, input logic [8:0] m);
    longint r;
    r = (longint'(x) * longint'(m)) / 256;
    if (r > 65535) return 16'hFFFF;
    return r[15:0];
  endfunction

  // Drive one control cycle just ahead of edge cyc+1 and predict the outcome.
  task automatic drive(input bit upd, input logic [AW-1:0] base, input logic [8:0] m,
                       input bit clr);
    int e;
    bit acc;
    e   = cyc + 1;
    acc = upd && (!frame_active || e >= last_e + PERIOD);
    bus.update      = upd;
    bus.base_addr   = base;
    bus.mod         = m;
    bus.overrun_clr = clr;
    if (acc) begin
      frame_active = 1'b1;
      last_e       = e;
      for (int k = 0; k < DEPTH; k++) begin
        logic [AW-1:0] addr;
        addr = base + AW'(k);
        addr_q.push_back('{c: e + k, a: addr});
        beat_q.push_back('{inten: scale(mem[addr][31:16], m), phase: mem[addr][15:0]});
      end
      start_q.push_back(e + RL + 1);
      busy_q.push_back('{c: e, v: 1'b1});
      busy_q.push_back('{c: e + RL + DEPTH, v: 1'b1});
      busy_q.push_back('{c: e + RL + DEPTH + 1, v: 1'b0});
    end
    if (upd && !acc) ovr_model = 1'b1;
    else if (clr)    ovr_model = 1'b0;
    @(posedge clk);
    #1;
    bus.update      = 1'b0;
    bus.overrun_clr = 1'b0;
    @(negedge clk);
    check("overrun", 32'(bus.overrun), 32'(ovr_model));
  endtask

  task automatic issue(input logic [AW-1:0] base, input logic [8:0] m);
    @(posedge clk);
    #1;
    drive(1'b1, base, m, 1'b0);
  endtask

  task automatic wait_edge_before(input int e);
    while (cyc < e - 1) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"},      32'(bus.busy),          32'd0);
    check({tag, "_overrun"},   32'(bus.overrun),       32'd0);
    check({tag, "_dout_valid"},32'(bus.dout_valid),    32'd0);
    check({tag, "_intensity"}, 32'(bus.intensity_out), 32'd0);
    check({tag, "_phase"},     32'(bus.phase_out),     32'd0);
    check({tag, "_bram_addr"}, 32'(bus.bram_addr),     32'd0);
  endtask

  // Monitor: beat 0 is strobed, the remaining DEPTH-1 beats follow back to back.
  int beats_left = 0;
  int beat_idx   = 0;

  task automatic compare_beat();
    beat_t b;
    if (beat_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL beat[%0d]: DUT beat with no expected data", beat_idx);
    end else begin
      b = beat_q.pop_front();
      check($sformatf("intensity[%0d]", beat_idx), 32'(bus.intensity_out), 32'(b.inten));
      check($sformatf("phase[%0d]", beat_idx),     32'(bus.phase_out),     32'(b.phase));
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        beats_left = 0;
      end else begin
        if (addr_q.size() > 0 && addr_q[0].c == cyc) begin
          check("bram_addr", 32'(bus.bram_addr), 32'(addr_q[0].a));
          void'(addr_q.pop_front());
        end
        if (busy_q.size() > 0 && busy_q[0].c == cyc) begin
          check("busy", 32'(bus.busy), 32'(busy_q[0].v));
          void'(busy_q.pop_front());
        end
        if (start_q.size() > 0 && start_q[0] < cyc) begin
          tests++;
          fails++;
          $display("FAIL frame_start: no beat 0 at cycle %0d", start_q[0]);
          void'(start_q.pop_front());
          for (int i = 0; i < DEPTH && beat_q.size() > 0; i++) void'(beat_q.pop_front());
        end
        if (bus.dout_valid && beats_left == 0) begin
          if (start_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL frame_start: unexpected dout_valid at cycle %0d", cyc);
          end else begin
            check("beat0_cycle", 32'(cyc), 32'(start_q.pop_front()));
            beat_idx = 0;
            compare_beat();
            beats_left = DEPTH - 1;
          end
        end else if (beats_left > 0) begin
          check("dout_valid_mid_frame", 32'(bus.dout_valid), 32'd0);
          beat_idx++;
          compare_beat();
          beats_left--;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int e1;
    int e2;
    bit quiet;
    bus.update      = 1'b0;
    bus.base_addr   = '0;
    bus.mod         = '0;
    bus.overrun_clr = 1'b0;
    for (int i = 0; i < MEM_SIZE; i++) mem[i] = {16'(i), 16'(16'hFFFF - i)};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Ramp frame at unity scale
    issue('0, 9'd256);
    repeat (PERIOD + 2) @(posedge clk);

    // Scale corner cases planted at the frame base, random data elsewhere
    for (int f = 0; f < 5; f++) begin
      logic [AW-1:0] b;
      logic [8:0]    m;
      b = AW'($urandom);
      m = (f == 4) ? 9'($urandom_range(0, 511)) : mods[f];
      for (int i = 0; i < MEM_SIZE; i++) mem[i] = $urandom;
      mem[b] = {specials[f], 16'($urandom)};
      issue(b, m);
      repeat (PERIOD) @(posedge clk);
    end

    // Address wrap past the top of the 8-bit space
    issue(8'hF0, 9'd256);
    repeat (PERIOD) @(posedge clk);

    // Overrun handling, then a back-to-back frame at the minimum period
    issue(8'h20, 9'd200);
    e1 = last_e;
    wait_edge_before(e1 + 10);
    drive(1'b1, 8'h33, 9'd77, 1'b0);
    wait_edge_before(e1 + 40);
    drive(1'b1, 8'h44, 9'd1, 1'b1);
    wait_edge_before(e1 + 60);
    drive(1'b0, 8'h00, 9'd0, 1'b1);
    wait_edge_before(e1 + PERIOD);
    drive(1'b1, 8'h80, 9'd384, 1'b0);
    e2 = last_e;

    // Asynchronous reset while beat 100 of the second frame is on the outputs
    while (cyc < e2 + RL + 1 + 100) begin
      @(posedge clk);
      #1;
    end
    #2;
    rst_n = 1'b0;
    beat_q.delete();
    start_q.delete();
    addr_q.delete();
    busy_q.delete();
    frame_active = 1'b0;
    ovr_model    = 1'b0;
    #1;
    check_outputs_zero("abort");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    quiet = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (bus.dout_valid || bus.busy || bus.intensity_out != 16'd0 || bus.phase_out != 16'd0)
        quiet = 1'b0;
    end
    check("no_resume_after_reset", 32'(quiet), 32'd1);

    issue(8'h10, 9'd300);
    repeat (PERIOD + 5) @(posedge clk);
    @(negedge clk);
    check("scoreboard_drained",
          32'(beat_q.size() + start_q.size() + addr_q.size() + busy_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
